// File: rtl/spawn_dispatcher.sv
// Spawn dispatcher: edge-detects per-core spawn toggles, queues requests in a FIFO, and starts them on idle cores.
// Define SPAWN_DISPATCH_RR_EN for round-robin core selection; otherwise the lowest-index idle core is chosen.

module spawn_pend_slot (
  input  logic       proc_clock,
  input  logic       reset_n,
  input  logic       ev,
  input  logic [7:0] ev_addr,
  input  logic       drain,
  output logic       vld,
  output logic       vld_nxt,
  output logic       drop,
  output logic [7:0] addr
);
  // A slot being drained this cycle is still occupied, so a same-cycle event is lost.
  assign drop    = ev & vld;
  assign vld_nxt = (ev & ~vld) | (vld & ~drain);

  always_ff @(posedge proc_clock or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= 1'b0;
      addr <= 8'h00;
    end else begin
      vld <= vld_nxt;
      if (ev && !vld) addr <= ev_addr;
    end
  end
endmodule

module spawn_dispatcher #(
  parameter int N_PROCS    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 proc_clock,
  input  logic                 reset_n,
  input  logic [N_PROCS-1:0]   TRIGGER_SPAWN,
  input  logic [8*N_PROCS-1:0] SPAWN_ADDR,
  input  logic                 BOOT_VALID,
  input  logic [7:0]           BOOT_ADDR,
  input  logic [N_PROCS-1:0]   RUN,
  output logic [N_PROCS-1:0]   START,
  output logic [8*N_PROCS-1:0] START_ADDR,
  output logic [5:0]           FIFO_COUNT,
  output logic [7:0]           DROP_CNT,
  output logic                 BUSY
);
  localparam int SLOTS = N_PROCS + 1;
  localparam int SW    = $clog2(SLOTS);
  localparam int KW    = $clog2(N_PROCS);
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CONFIRM = 2'd2;

  logic [N_PROCS-1:0]          trig_q;
  logic [SLOTS-1:0]            ev;
  logic [SLOTS-1:0][7:0]       ev_addr;
  logic [SLOTS-1:0]            pend_vld, pend_vld_nxt, drop_v;
  logic [SLOTS-1:0][7:0]       pend_addr;
  logic [SW-1:0]               rr_ptr, rr_ptr_nxt;
  logic                        gnt_vld;
  logic [SW-1:0]               gnt_idx;
  logic                        push, pop, full, empty;
  logic [7:0]                  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [5:0]                  count_nxt;
  logic [1:0]                  state, state_nxt;
  logic [KW-1:0]               k_q;
  logic [1:0]                  tmo;
  logic                        sel_vld;
  logic [KW-1:0]               sel_idx;
  logic [N_PROCS-1:0][7:0]     start_addr_q;
  logic [3:0]                  n_drop;
  logic [8:0]                  drop_sum;

  // Slot N_PROCS is the boot request; it is a pulse, not a toggle.
  assign ev = {BOOT_VALID, TRIGGER_SPAWN ^ trig_q};
  for (genvar i = 0; i < N_PROCS; i++) begin : g_addr
    assign ev_addr[i] = SPAWN_ADDR[8*i +: 8];
  end
  assign ev_addr[N_PROCS] = BOOT_ADDR;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    spawn_pend_slot u_slot (
      .proc_clock (proc_clock),
      .reset_n    (reset_n),
      .ev         (ev[i]),
      .ev_addr    (ev_addr[i]),
      .drain      (push && (gnt_idx == SW'(i))),
      .vld        (pend_vld[i]),
      .vld_nxt    (pend_vld_nxt[i]),
      .drop       (drop_v[i]),
      .addr       (pend_addr[i])
    );
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < SLOTS; i++) n_drop = n_drop + {3'b000, drop_v[i]};
    drop_sum = {1'b0, DROP_CNT} + {5'b00000, n_drop};
  end

  // Round-robin search over pending slots, starting at rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < SLOTS; j++) begin
      if (!gnt_vld && pend_vld[(int'(rr_ptr) + j) % SLOTS]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'((int'(rr_ptr) + j) % SLOTS);
      end
    end
  end
  assign rr_ptr_nxt = (gnt_idx == SW'(SLOTS-1)) ? '0 : gnt_idx + 1'b1;

  assign empty     = (FIFO_COUNT == 6'd0);
  assign full      = (FIFO_COUNT == 6'(FIFO_DEPTH));
  assign pop       = (state == S_IDLE) && !empty && sel_vld;
  assign push      = gnt_vld && (!full || pop);
  assign count_nxt = FIFO_COUNT + {5'b00000, push} - {5'b00000, pop};

`ifdef SPAWN_DISPATCH_RR_EN
  logic [KW-1:0] last_core;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int j = 1; j <= N_PROCS; j++) begin
      if (!sel_vld && !RUN[(int'(last_core) + j) % N_PROCS]) begin
        sel_vld = 1'b1;
        sel_idx = KW'((int'(last_core) + j) % N_PROCS);
      end
    end
  end

  always_ff @(posedge proc_clock or negedge reset_n) begin
    if (!reset_n)  last_core <= KW'(N_PROCS-1);
    else if (pop)  last_core <= sel_idx;
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int j = 0; j < N_PROCS; j++) begin
      if (!sel_vld && !RUN[j]) begin
        sel_vld = 1'b1;
        sel_idx = KW'(j);
      end
    end
  end
`endif

  // Selection happens only in IDLE, so the in-flight core can never be re-picked mid-handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pop) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_CONFIRM;
      S_CONFIRM: if (RUN[k_q] || tmo == 2'd3) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge proc_clock) begin
    if (push) fifo_mem[wr_ptr] <= pend_addr[gnt_idx];
  end

  always_ff @(posedge proc_clock or negedge reset_n) begin
    if (!reset_n) begin
      trig_q       <= '0;
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      FIFO_COUNT   <= 6'd0;
      DROP_CNT     <= 8'd0;
      BUSY         <= 1'b0;
      state        <= S_IDLE;
      k_q          <= '0;
      tmo          <= 2'd0;
      start_addr_q <= '0;
    end else begin
      trig_q <= TRIGGER_SPAWN;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= rr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr                <= rd_ptr + 1'b1;
        k_q                   <= sel_idx;
        start_addr_q[sel_idx] <= fifo_mem[rd_ptr];
      end
      FIFO_COUNT <= count_nxt;
      DROP_CNT   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      BUSY       <= (|pend_vld_nxt) || (count_nxt != 6'd0) || (state_nxt != S_IDLE);
      state      <= state_nxt;
      tmo        <= (state == S_CONFIRM) ? tmo + 2'd1 : 2'd0;
    end
  end

  // START decodes straight from state so an async reset kills the pulse at once.
  assign START      = (state == S_ISSUE) ? (N_PROCS'(1) << k_q) : '0;
  assign START_ADDR = start_addr_q;

endmodule

// File: tb/tb_spawn_dispatcher.sv
// Directed bench for spawn_dispatcher (N_PROCS=4, FIFO_DEPTH=8, fixed-priority core selection).
module tb_spawn_dispatcher;
  logic        proc_clock = 1'b0;
  logic        reset_n;
  logic [3:0]  TRIGGER_SPAWN;
  logic [31:0] SPAWN_ADDR;
  logic        BOOT_VALID;
  logic [7:0]  BOOT_ADDR;
  logic [3:0]  RUN;
  logic [3:0]  START;
  logic [31:0] START_ADDR;
  logic [5:0]  FIFO_COUNT;
  logic [7:0]  DROP_CNT;
  logic        BUSY;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] es, run_nx, seen;

  spawn_dispatcher #(.N_PROCS(4), .FIFO_DEPTH(8)) dut (
    .proc_clock    (proc_clock),
    .reset_n       (reset_n),
    .TRIGGER_SPAWN (TRIGGER_SPAWN),
    .SPAWN_ADDR    (SPAWN_ADDR),
    .BOOT_VALID    (BOOT_VALID),
    .BOOT_ADDR     (BOOT_ADDR),
    .RUN           (RUN),
    .START         (START),
    .START_ADDR    (START_ADDR),
    .FIFO_COUNT    (FIFO_COUNT),
    .DROP_CNT      (DROP_CNT),
    .BUSY          (BUSY)
  );

  always #5 proc_clock = ~proc_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge proc_clock);
    #1;
  endtask

  task automatic toggle(input int c, input logic [7:0] a);
    TRIGGER_SPAWN[c]     = ~TRIGGER_SPAWN[c];
    SPAWN_ADDR[8*c +: 8] = a;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    TRIGGER_SPAWN = '0;
    BOOT_VALID    = 1'b0;
    RUN           = '0;
    repeat (2) @(posedge proc_clock);
    @(negedge proc_clock);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; TRIGGER_SPAWN = '0; SPAWN_ADDR = '0;
    BOOT_VALID = 1'b0; BOOT_ADDR = '0; RUN = '0;

    // Reset state and single spawn
    do_reset();
    chk("rst_start", START, 0);
    chk("rst_start_addr", START_ADDR, 0);
    chk("rst_count", FIFO_COUNT, 0);
    chk("rst_drop", DROP_CNT, 0);
    chk("rst_busy", BUSY, 0);
    toggle(1, 8'h40);
    tick(); chk("single_busy_c1", BUSY, 1); chk("single_start_c1", START, 0);
    tick(); chk("single_count_c2", FIFO_COUNT, 1); chk("single_start_c2", START, 0);
    tick(); chk("single_start_c3", START, 4'b0001); chk("single_addr_c3", START_ADDR[7:0], 8'h40);
    chk("single_count_c3", FIFO_COUNT, 0);
    tick(); chk("single_start_c4", START, 0); chk("single_busy_c4", BUSY, 1);
    RUN = 4'b0001;
    tick(); chk("single_busy_idle", BUSY, 0); chk("single_addr_held", START_ADDR[7:0], 8'h40);

    // Simultaneous requests, core 0 busy
    do_reset();
    RUN = 4'b0001;
    toggle(0, 8'h10); toggle(2, 8'h20); toggle(3, 8'h30);
    BOOT_VALID = 1'b1; BOOT_ADDR = 8'h50;
    run_nx = '0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      BOOT_VALID = 1'b0;
      RUN = RUN | run_nx;
      case (t)
        3:       es = 4'b0010;
        6:       es = 4'b0100;
        9:       es = 4'b1000;
        default: es = 4'b0000;
      endcase
      chk($sformatf("simul_start_c%0d", t), START, es);
      run_nx = es;
    end
    chk("simul_addr1", START_ADDR[15:8], 8'h10);
    chk("simul_addr2", START_ADDR[23:16], 8'h20);
    chk("simul_addr3", START_ADDR[31:24], 8'h30);
    chk("simul_count", FIFO_COUNT, 1);
    chk("simul_busy", BUSY, 1);

    // Backpressure, then double toggle while full
    do_reset();
    RUN = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      BOOT_VALID = 1'b1; BOOT_ADDR = 8'hA0 + 8'(i);
      tick();
      BOOT_VALID = 1'b0;
      tick();
    end
    chk("bp_count", FIFO_COUNT, 8);
    chk("bp_drop", DROP_CNT, 1);
    chk("bp_busy", BUSY, 1);
    chk("bp_no_start", START, 0);
    toggle(0, 8'h77); tick();
    toggle(0, 8'h78); tick();
    chk("dbl_drop", DROP_CNT, 2);
    RUN = 4'b1011;
    tick();
    chk("bp_release_start", START, 4'b0100);
    chk("bp_release_addr", START_ADDR[23:16], 8'hA0);

    // Confirm timeout and reissue to the same idle core
    do_reset();
    RUN = 4'b1101;
    BOOT_VALID = 1'b1; BOOT_ADDR = 8'h61;
    toggle(2, 8'h62);
    for (int t = 1; t <= 10; t++) begin
      tick();
      BOOT_VALID = 1'b0;
      es = (t == 3 || t == 9) ? 4'b0010 : 4'b0000;
      chk($sformatf("tmo_start_c%0d", t), START, es);
      if (t == 3) chk("tmo_addr_first", START_ADDR[15:8], 8'h62);
      if (t == 9) chk("tmo_addr_second", START_ADDR[15:8], 8'h61);
    end

    // Asynchronous reset in the ISSUE cycle
    do_reset();
    toggle(3, 8'h99);
    tick(); tick(); tick();
    chk("rstmid_start_pre", START, 4'b0001);
    chk("rstmid_addr_pre", START_ADDR[7:0], 8'h99);
    #2;
    reset_n = 1'b0;
    TRIGGER_SPAWN = '0;
    #1;
    chk("rstmid_start", START, 0);
    chk("rstmid_start_addr", START_ADDR, 0);
    chk("rstmid_count", FIFO_COUNT, 0);
    chk("rstmid_drop", DROP_CNT, 0);
    chk("rstmid_busy", BUSY, 0);
    @(negedge proc_clock);
    reset_n = 1'b1;
    tick();
    seen = '0;
    repeat (8) begin
      tick();
      seen = seen | START;
    end
    chk("rstmid_quiet", seen, 0);
    toggle(1, 8'h5A);
    tick(); tick(); tick();
    chk("rstmid_new_start", START, 4'b0001);
    chk("rstmid_new_addr", START_ADDR[7:0], 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
